// File: rtl/acc_psw_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acc_psw_unit
//  Description : Accumulator plus 8085-style PSW flag register with multi-cycle
//                STORE / PUSH_PSW / POP_PSW transfers over a shared data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_psw_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] data_bus,
    input  logic [WIDTH-1:0] alu_data,
    input  logic [4:0]       alu_flags,
    input  logic [3:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             bus_oe,
    output logic             xfer_strobe,
    output logic             xfer_phase,
    output logic [WIDTH-1:0] acc_out,
    output logic [7:0]       flags_out
);

    localparam logic [3:0] c_OP_LOAD_ALU    = 4'd1;
    localparam logic [3:0] c_OP_LOAD_ALU_NF = 4'd2;
    localparam logic [3:0] c_OP_LOAD_BUS    = 4'd3;
    localparam logic [3:0] c_OP_STORE       = 4'd4;
    localparam logic [3:0] c_OP_RLC         = 4'd5;
    localparam logic [3:0] c_OP_RRC         = 4'd6;
    localparam logic [3:0] c_OP_RAL         = 4'd7;
    localparam logic [3:0] c_OP_RAR         = 4'd8;
    localparam logic [3:0] c_OP_CMA         = 4'd9;
    localparam logic [3:0] c_OP_STC         = 4'd10;
    localparam logic [3:0] c_OP_CMC         = 4'd11;
    localparam logic [3:0] c_OP_PUSH_PSW    = 4'd12;
    localparam logic [3:0] c_OP_POP_PSW     = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ST_DRV = 3'd1,
        ST_PU_A   = 3'd2,
        ST_PU_F   = 3'd3,
        ST_PO_F   = 3'd4,
        ST_PO_A   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [7:0]       r_flags;
    logic [7:0]       w_flags_nxt;
    logic             r_bus_oe;
    logic             r_xfer_strobe;
    logic             r_xfer_phase;
    logic             w_oe_nxt;
    logic             w_strobe_nxt;
    logic             w_phase_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_psw_word;
    logic [WIDTH-1:0] w_drive;

    // Fixed PSW bits: bit1 always set, bits 5 and 3 always clear.
    function automatic logic [7:0] f_psw_mask(input logic [7:0] f);
        return {f[7:6], 1'b0, f[4], 1'b0, f[2], 1'b1, f[0]};
    endfunction

    assign w_accept = (r_state == ST_IDLE) && op_valid;

    // Next state plus registered-output decode of that next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        c_OP_STORE:    w_state_nxt = ST_ST_DRV;
                        c_OP_PUSH_PSW: w_state_nxt = ST_PU_A;
                        c_OP_POP_PSW:  w_state_nxt = ST_PO_F;
                        default:       w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_ST_DRV: w_state_nxt = ST_IDLE;
            ST_PU_A:   w_state_nxt = ST_PU_F;
            ST_PU_F:   w_state_nxt = ST_IDLE;
            ST_PO_F:   w_state_nxt = ST_PO_A;
            ST_PO_A:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_oe_nxt     = (w_state_nxt == ST_ST_DRV) || (w_state_nxt == ST_PU_A) ||
                       (w_state_nxt == ST_PU_F);
        w_strobe_nxt = (w_state_nxt != ST_IDLE);
        w_phase_nxt  = (w_state_nxt == ST_PU_F) || (w_state_nxt == ST_PO_F);
    end

    // Accumulator / PSW next values: single-cycle ops in IDLE, bus samples in POP.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_flags_nxt = r_flags;
        if (w_accept) begin
            case (op)
                c_OP_LOAD_ALU: begin
                    w_acc_nxt   = alu_data;
                    w_flags_nxt = f_psw_mask({alu_flags[4:3], 1'b0, alu_flags[2],
                                              1'b0, alu_flags[1], 1'b1, alu_flags[0]});
                end
                c_OP_LOAD_ALU_NF: w_acc_nxt = alu_data;
                c_OP_LOAD_BUS:    w_acc_nxt = data_bus;
                c_OP_RLC: begin
                    w_acc_nxt      = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
                    w_flags_nxt[0] = r_acc[WIDTH-1];
                end
                c_OP_RRC: begin
                    w_acc_nxt      = {r_acc[0], r_acc[WIDTH-1:1]};
                    w_flags_nxt[0] = r_acc[0];
                end
                c_OP_RAL: begin
                    w_acc_nxt      = {r_acc[WIDTH-2:0], r_flags[0]};
                    w_flags_nxt[0] = r_acc[WIDTH-1];
                end
                c_OP_RAR: begin
                    w_acc_nxt      = {r_flags[0], r_acc[WIDTH-1:1]};
                    w_flags_nxt[0] = r_acc[0];
                end
                c_OP_CMA: w_acc_nxt      = ~r_acc;
                c_OP_STC: w_flags_nxt[0] = 1'b1;
                c_OP_CMC: w_flags_nxt[0] = ~r_flags[0];
                default: ;
            endcase
        end else if (r_state == ST_PO_F) begin
            w_flags_nxt = f_psw_mask(data_bus[7:0]);
        end else if (r_state == ST_PO_A) begin
            w_acc_nxt = data_bus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_flags       <= 8'h02;
            r_bus_oe      <= 1'b0;
            r_xfer_strobe <= 1'b0;
            r_xfer_phase  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_flags       <= w_flags_nxt;
            r_bus_oe      <= w_oe_nxt;
            r_xfer_strobe <= w_strobe_nxt;
            r_xfer_phase  <= w_phase_nxt;
        end
    end

    always_comb begin
        w_psw_word      = '0;
        w_psw_word[7:0] = r_flags;
    end

    assign w_drive  = (r_state == ST_PU_F) ? w_psw_word : r_acc;
    assign data_bus = r_bus_oe ? w_drive : {WIDTH{1'bz}};

    assign op_ready    = (r_state == ST_IDLE);
    assign bus_oe      = r_bus_oe;
    assign xfer_strobe = r_xfer_strobe;
    assign xfer_phase  = r_xfer_phase;
    assign acc_out     = r_acc;
    assign flags_out   = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_acc_psw_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_psw_unit
//  Description : Randomized + directed self-checking bench for acc_psw_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_psw_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 8-bit instance, followed by the reference model
    logic [7:0] op_d8 = '0, alu_d8 = '0, tb_drv8 = '0;
    logic [4:0] alu_f8 = '0;
    logic [3:0] op8 = '0;
    logic       valid8 = 1'b0, tb_en8 = 1'b0;
    wire  [7:0] bus8;
    logic       ready8, oe8, strobe8, phase8;
    logic [7:0] acc8, flags8;
    assign bus8 = tb_en8 ? tb_drv8 : 8'bz;

    acc_psw_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .data_bus(bus8), .alu_data(alu_d8),
        .alu_flags(alu_f8), .op(op8), .op_valid(valid8), .op_ready(ready8),
        .bus_oe(oe8), .xfer_strobe(strobe8), .xfer_phase(phase8),
        .acc_out(acc8), .flags_out(flags8)
    );

    // 16-bit instance, checked with directed literals only
    logic [15:0] alu_d16 = '0;
    logic [4:0]  alu_f16 = '0;
    logic [3:0]  op16 = '0;
    logic        valid16 = 1'b0;
    wire  [15:0] bus16;
    logic        ready16, oe16, strobe16, phase16;
    logic [15:0] acc16;
    logic [7:0]  flags16;

    acc_psw_unit #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .data_bus(bus16), .alu_data(alu_d16),
        .alu_flags(alu_f16), .op(op16), .op_valid(valid16), .op_ready(ready16),
        .bus_oe(oe16), .xfer_strobe(strobe16), .xfer_phase(phase16),
        .acc_out(acc16), .flags_out(flags16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_z(input string name, input logic is_z, input logic [31:0] act);
        total++;
        if (!is_z) begin
            bad++;
            $display("FAIL %s: got %h expected high-Z at %0t", name, act, $time);
        end
    endtask

    // ---------------- reference model (8-bit) ----------------
    // Each accepted multi-cycle op becomes a list of bus slots; one slot per cycle.
    typedef struct packed {
        logic drv;   // 1 = unit drives, 0 = unit samples
        logic ph;    // 0 = accumulator item, 1 = flag item
    } slot_t;

    slot_t      q[$];
    logic [7:0] m_acc;
    logic [7:0] m_flags;

    function automatic logic [7:0] psw_from_alu(input logic [4:0] f);
        // {S,Z,AC,P,CY} -> {S,Z,0,AC,0,P,1,CY}
        return (8'(f[4]) << 7) | (8'(f[3]) << 6) | (8'(f[2]) << 4) |
               (8'(f[1]) << 2) | 8'h02 | 8'(f[0]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_acc   = 8'h00;
            m_flags = 8'h02;
        end else if (q.size() != 0) begin
            slot_t s;
            s = q.pop_front();
            if (!s.drv) begin
                if (s.ph) m_flags = (bus8 & 8'hD5) | 8'h02;
                else      m_acc   = bus8;
            end
        end else if (valid8) begin
            logic cy;
            cy = m_flags[0];
            case (op8)
                4'd1: begin m_acc = alu_d8; m_flags = psw_from_alu(alu_f8); end
                4'd2: m_acc = alu_d8;
                4'd3: m_acc = bus8;
                4'd4: q.push_back('{drv: 1'b1, ph: 1'b0});
                4'd5: begin m_flags[0] = m_acc[7]; m_acc = (m_acc << 1) | (m_acc >> 7); end
                4'd6: begin m_flags[0] = m_acc[0]; m_acc = (m_acc >> 1) | (m_acc << 7); end
                4'd7: begin m_flags[0] = m_acc[7]; m_acc = (m_acc << 1) | 8'(cy); end
                4'd8: begin m_flags[0] = m_acc[0]; m_acc = (m_acc >> 1) | (8'(cy) << 7); end
                4'd9: m_acc = 8'hFF - m_acc;
                4'd10: m_flags[0] = 1'b1;
                4'd11: m_flags[0] = !cy;
                4'd12: begin
                    q.push_back('{drv: 1'b1, ph: 1'b0});
                    q.push_back('{drv: 1'b1, ph: 1'b1});
                end
                4'd13: begin
                    q.push_back('{drv: 1'b0, ph: 1'b1});
                    q.push_back('{drv: 1'b0, ph: 1'b0});
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic       busy;
        slot_t      s;
        busy = (q.size() != 0);
        s    = busy ? q[0] : '0;
        chk("acc", 32'(acc8), 32'(m_acc));
        chk("flags", 32'(flags8), 32'(m_flags));
        chk("op_ready", 32'(ready8), 32'(!busy));
        chk("bus_oe", 32'(oe8), 32'(busy && s.drv));
        chk("xfer_strobe", 32'(strobe8), 32'(busy));
        chk("xfer_phase", 32'(phase8), 32'(busy && s.ph));
        if (busy && s.drv)
            chk("bus_drive", 32'(bus8), s.ph ? 32'(m_flags) : 32'(m_acc));
        else if (!tb_en8)
            chk_z("bus_idle_z", bus8 === 8'bz, 32'(bus8));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] d, input logic [4:0] f);
        op8 = o; alu_d8 = d; alu_f8 = f; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] o, input logic [15:0] d, input logic [4:0] f);
        op16 = o; alu_d16 = d; alu_f16 = f; valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #12;
        chk("rst_acc", 32'(acc8), 32'h00);
        chk("rst_flags", 32'(flags8), 32'h02);
        chk("rst_ready", 32'(ready8), 32'h1);
        chk("rst_oe_strobe_phase", {29'b0, oe8, strobe8, phase8}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Literal pins for the model
        issue8(4'd1, 8'hA5, 5'b10011);
        chk("load_alu_acc", 32'(acc8), 32'hA5);
        chk("load_alu_flags", 32'(flags8), 32'h87);
        issue8(4'd5, 8'h00, 5'h0);
        chk("rlc_acc", 32'(acc8), 32'h4B);
        chk("rlc_flags", 32'(flags8), 32'h87);
        issue8(4'd1, 8'h01, 5'b00000);
        issue8(4'd8, 8'h00, 5'h0);
        chk("rar_acc", 32'(acc8), 32'h00);
        chk("rar_cy", 32'(flags8[0]), 32'h1);
        issue8(4'd7, 8'h00, 5'h0);
        chk("ral_acc", 32'(acc8), 32'h01);
        chk("ral_cy", 32'(flags8[0]), 32'h0);
        issue8(4'd10, 8'h00, 5'h0);
        chk("stc_cy", 32'(flags8[0]), 32'h1);
        issue8(4'd11, 8'h00, 5'h0);
        chk("cmc_cy", 32'(flags8[0]), 32'h0);
        issue8(4'd1, 8'h0F, 5'b00000);
        issue8(4'd9, 8'h00, 5'h0);
        chk("cma_acc", 32'(acc8), 32'hF0);

        // PUSH_PSW
        issue8(4'd1, 8'h3C, 5'b11111);
        chk("psw_d7", 32'(flags8), 32'hD7);
        issue8(4'd12, 8'h00, 5'h0);
        chk("push1_bus", 32'(bus8), 32'h3C);
        chk("push1_phase", 32'(phase8), 32'h0);
        chk("push1_ready", 32'(ready8), 32'h0);
        tick();
        chk("push2_bus", 32'(bus8), 32'hD7);
        chk("push2_phase", 32'(phase8), 32'h1);
        chk("push2_ready", 32'(ready8), 32'h0);
        tick();
        chk_z("push_after_z", bus8 === 8'bz, 32'(bus8));
        chk("push_after_ready", 32'(ready8), 32'h1);

        // POP_PSW
        issue8(4'd13, 8'h00, 5'h0);
        tb_drv8 = 8'hFF; tb_en8 = 1'b1;
        chk("pop1_oe", 32'(oe8), 32'h0);
        tick();
        chk("pop_flags", 32'(flags8), 32'hD7);
        chk("pop2_oe", 32'(oe8), 32'h0);
        tb_drv8 = 8'h81;
        tick();
        tb_en8 = 1'b0;
        chk("pop_acc", 32'(acc8), 32'h81);
        chk("pop_ready", 32'(ready8), 32'h1);

        // Asynchronous reset while the flag item is on the bus
        issue8(4'd12, 8'h00, 5'h0);
        tick();
        chk("pre_rst_oe", 32'(oe8), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk_z("rst_bus_z", bus8 === 8'bz, 32'(bus8));
        chk("rst_mid_acc", 32'(acc8), 32'h00);
        chk("rst_mid_flags", 32'(flags8), 32'h02);
        chk("rst_mid_ready", 32'(ready8), 32'h1);
        tick();
        reset = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic front_drv, front_smp;
            front_drv = (q.size() != 0) && q[0].drv;
            front_smp = (q.size() != 0) && !q[0].drv;
            valid8 = ($urandom_range(3) != 0);
            op8    = 4'($urandom_range(15));
            alu_d8 = 8'($urandom);
            alu_f8 = 5'($urandom);
            tb_drv8 = 8'($urandom);
            if (front_drv)                  tb_en8 = 1'b0;
            else if (front_smp || op8 == 4'd3) tb_en8 = 1'b1;
            else                            tb_en8 = ($urandom_range(1) != 0);
            tick();
        end
        valid8 = 1'b0;
        tb_en8 = 1'b0;
        tick();

        // WIDTH = 16
        issue16(4'd1, 16'hBEEF, 5'b10011);
        issue16(4'd4, 16'h0000, 5'h0);
        chk("w16_store_bus", 32'(bus16), 32'hBEEF);
        chk("w16_store_oe", {29'b0, oe16, strobe16, phase16}, 32'h6);
        tick();
        chk_z("w16_store_after_z", bus16 === 16'bz, 32'(bus16));
        chk("w16_store_after_ready", 32'(ready16), 32'h1);
        issue16(4'd12, 16'h0000, 5'h0);
        op16 = 4'd9; valid16 = 1'b1;
        chk("w16_push1_bus", 32'(bus16), 32'hBEEF);
        tick();
        chk("w16_push2_bus", 32'(bus16), 32'h0087);
        chk("w16_busy_acc", 32'(acc16), 32'hBEEF);
        tick();
        chk("w16_idle_ready", 32'(ready16), 32'h1);
        chk("w16_held_not_taken", 32'(acc16), 32'hBEEF);
        tick();
        valid16 = 1'b0;
        chk("w16_held_taken", 32'(acc16), 32'h4110);
        chk("w16_flags", 32'(flags16), 32'h87);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_psw_unit.md
Name: acc_psw_unit

Overview:
- Parametrised accumulator plus 8085-style flag register (PSW) for the datapath.
- Loads from the ALU result or the shared tri-state data bus.
- Executes in-place accumulator ops: rotate, complement, carry set/complement.
- Sequences multi-cycle STORE, PUSH_PSW and POP_PSW transfers over the data bus with a valid/ready handshake toward the control unit.

Parameters:
- WIDTH, 8, accumulator and data bus width in bits; legal range 8..32.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- data_bus  inout  WIDTH  shared tri-state data bus
- alu_data  in  WIDTH  ALU result
- alu_flags  in  5  ALU flags {S,Z,AC,P,CY}
- op  in  4  operation code
- op_valid  in  1  op presented this cycle
- op_ready  out  1  unit can accept an op
- bus_oe  out  1  unit is driving data_bus this cycle
- xfer_strobe  out  1  bus transfer cycle (drive or sample)
- xfer_phase  out  1  0 = accumulator item, 1 = flag item
- acc_out  out  WIDTH  current accumulator
- flags_out  out  8  PSW byte {S,Z,0,AC,0,P,1,CY}

Behaviour:
- Reset: acc = 0, flags_out = 8'h02, FSM = IDLE, op_ready = 1, bus_oe = 0, xfer_strobe = 0, xfer_phase = 0.
- Reset is asynchronous: data_bus releases to Z immediately, including mid-transfer.
- Handshake:
  - Op is accepted on a rising edge with op_valid && op_ready.
  - op_ready = 1 only in IDLE.
  - Single-cycle ops take effect at the accepting edge.
- Opcodes:
  - 0 NOP
  - 1 LOAD_ALU: acc <= alu_data; flags <= alu_flags.
  - 2 LOAD_ALU_NF: acc <= alu_data; flags unchanged.
  - 3 LOAD_BUS: acc <= data_bus; flags unchanged.
  - 4 STORE
  - 5 RLC: acc <= {acc[W-2:0],acc[W-1]}; CY <= acc[W-1].
  - 6 RRC: acc <= {acc[0],acc[W-1:1]}; CY <= acc[0].
  - 7 RAL: acc <= {acc[W-2:0],CY}; CY <= acc[W-1].
  - 8 RAR: acc <= {CY,acc[W-1:1]}; CY <= acc[0].
  - 9 CMA: acc <= ~acc.
  - 10 STC: CY <= 1.
  - 11 CMC: CY <= ~CY.
  - 12 PUSH_PSW
  - 13 POP_PSW
  - 14, 15: reserved, treated as NOP.
- Rotates alter CY only; S, Z, AC, P are untouched.
- Fixed PSW bits are forced on every write: bit1 = 1, bits 5 and 3 = 0.
- FSM states: IDLE, ST_DRV, PU_A, PU_F, PO_F, PO_A.
  - IDLE -> ST_DRV on STORE; PU_A on PUSH_PSW; PO_F on POP_PSW.
  - ST_DRV (1 cycle): drive acc; bus_oe = 1, xfer_strobe = 1, xfer_phase = 0; -> IDLE.
  - PU_A: drive acc; xfer_phase = 0; -> PU_F.
  - PU_F: drive {WIDTH-8 zeros, flags}; xfer_phase = 1; -> IDLE.
  - PO_F: bus_oe = 0, xfer_strobe = 1, xfer_phase = 1; at end-of-cycle edge flags <= masked data_bus[7:0]; -> PO_A.
  - PO_A: xfer_phase = 0; at edge acc <= data_bus; -> IDLE.
- Latencies:
  - STORE occupies 1 cycle after acceptance.
  - PUSH and POP occupy 2 cycles each.
  - op_ready returns high the cycle after the last transfer cycle.
- bus_oe, xfer_strobe and xfer_phase are registered FSM decodes. data_bus = bus_oe ? drive value : Z. No drive in any other state.
- acc_out and flags_out always reflect registers, also during transfers.
- Back-to-back single-cycle ops are accepted every cycle.
- op_valid while op_ready = 0 is ignored, not queued; the control unit holds op_valid.
- Parity P is supplied by the ALU; the unit never recomputes flags except CY.

Test Plan:
- Reset during PU_F with bus driven -> data_bus Z immediately; acc = 0, flags_out = 8'h02, op_ready = 1.
- LOAD_ALU alu_data = 8'hA5, alu_flags = 5'b10011 -> acc = 8'hA5, flags_out = 8'h87; then RLC -> acc = 8'h4B, flags_out = 8'h87 (CY = 1).
- acc = 8'h01, CY = 0: RAR -> acc = 8'h00, CY = 1; then RAL -> acc = 8'h01, CY = 0; STC then CMC -> CY = 0; CMA on 8'h0F -> 8'hF0.
- acc = 8'h3C, flags = 8'hD7: PUSH_PSW -> cycle1 bus = 8'h3C, xfer_phase = 0; cycle2 bus = 8'hD7, xfer_phase = 1; op_ready low both cycles; bus Z afterwards.
- POP_PSW with bench driving 8'hFF then 8'h81 -> flags_out = 8'hD7 (masked), acc = 8'h81; bus_oe = 0 throughout.
- WIDTH = 16: STORE with acc = 16'hBEEF -> bus = 16'hBEEF for exactly one cycle; PUSH flag cycle drives 16'h00xx; op_valid held during busy -> op accepted only after return to IDLE.
